// File: rtl/wb_secmem_master.sv
// Wishbone classic master driving an encrypted-SRAM slave.
// Runs KEY/WRITE/READ/ALARM commands with status polling and ack timeout.
module wb_secmem_master #(
  parameter int SRAM_ADDR_WD = 8,
  parameter int SRAM_DATA_WD = 32,
  parameter int ACK_TIMEOUT  = 16,
  parameter int POLL_MAX     = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [SRAM_ADDR_WD-1:0]   cmd_addr,
  input  logic [31:0]               cmd_wdata,
  input  logic [127:0]              key_i,
  output logic                      rsp_valid,
  output logic                      rsp_err,
  output logic [31:0]               rsp_rdata,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [SRAM_ADDR_WD-1:0]   wb_adr_o,
  output logic [SRAM_DATA_WD-1:0]   wb_dat_o,
  output logic [SRAM_DATA_WD/8-1:0] wb_sel_o,
  input  logic [SRAM_DATA_WD-1:0]   wb_dat_i,
  input  logic                      wb_ack_i
);

  localparam int AW = SRAM_ADDR_WD;
  localparam int DW = SRAM_DATA_WD;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_BUS        = 3'd1;
  localparam logic [2:0] S_GAP        = 3'd2;
  localparam logic [2:0] S_POLL       = 3'd3;
  localparam logic [2:0] S_POLL_GAP   = 3'd4;
  localparam logic [2:0] S_RESULT     = 3'd5;
  localparam logic [2:0] S_RESULT_GAP = 3'd6;
  localparam logic [2:0] S_DONE       = 3'd7;

  localparam logic [1:0] OP_KEY   = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_ALARM = 2'd3;

  localparam logic [AW-1:0] A_KEY   = AW'(0);
  localparam logic [AW-1:0] A_RES   = AW'(1);
  localparam logic [AW-1:0] A_STAT  = AW'(2);
  localparam logic [AW-1:0] A_ALARM = AW'(3);
  localparam logic [AW-1:0] A_SRAM  = AW'(4);

  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [PW-1:0] PMAX     = PW'(POLL_MAX);

  logic [2:0]    state;
  logic [1:0]    op_q;
  logic [127:0]  key_q;
  logic [1:0]    key_cnt;
  logic [TW-1:0] tmo;
  logic [PW-1:0] polls;
  logic          poll_ok;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign wb_sel_o  = '1;

  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      key_q     <= '0;
      key_cnt   <= '0;
      tmo       <= '0;
      polls     <= '0;
      poll_ok   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (cmd_valid) begin
          op_q      <= cmd_op;
          key_q     <= {key_i[95:0], 32'd0};
          key_cnt   <= '0;
          polls     <= '0;
          tmo       <= '0;
          poll_ok   <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          // register window is not reachable as SRAM data
          if (cmd_op inside {OP_WRITE, OP_READ} && cmd_addr < A_SRAM) begin
            rsp_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= S_BUS;
            unique case (cmd_op)
              OP_KEY: begin
                wb_we_o  <= 1'b1;
                wb_adr_o <= A_KEY;
                wb_dat_o <= DW'(key_i[127:96]);
              end
              OP_WRITE: begin
                wb_we_o  <= 1'b1;
                wb_adr_o <= cmd_addr;
                wb_dat_o <= DW'(cmd_wdata);
              end
              OP_READ: begin
                wb_we_o  <= 1'b0;
                wb_adr_o <= cmd_addr;
                wb_dat_o <= '0;
              end
              default: begin
                wb_we_o  <= 1'b1;
                wb_adr_o <= A_ALARM;
                wb_dat_o <= '0;
              end
            endcase
          end
        end

        S_BUS, S_POLL, S_RESULT: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            tmo      <= '0;
            if (state == S_BUS) begin
              state <= S_GAP;
            end else if (state == S_POLL) begin
              polls   <= polls + 1'b1;
              poll_ok <= (wb_dat_i[1:0] == 2'b00);
              state   <= S_POLL_GAP;
            end else begin
              rsp_rdata <= 32'(wb_dat_i);
              state     <= S_RESULT_GAP;
            end
          end else if (tmo == TMO_LAST) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            rsp_err  <= 1'b1;
            state    <= S_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        S_GAP: begin
          unique case (op_q)
            OP_KEY: begin
              if (key_cnt == 2'd3) begin
                state <= S_DONE;
              end else begin
                key_cnt  <= key_cnt + 1'b1;
                key_q    <= {key_q[95:0], 32'd0};
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= 1'b1;
                wb_adr_o <= A_KEY;
                wb_dat_o <= DW'(key_q[127:96]);
                tmo      <= '0;
                state    <= S_BUS;
              end
            end
            OP_WRITE, OP_READ: begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_adr_o <= A_STAT;
              wb_dat_o <= '0;
              tmo      <= '0;
              state    <= S_POLL;
            end
            default: state <= S_DONE;
          endcase
        end

        S_POLL_GAP: begin
          if (poll_ok) begin
            if (op_q == OP_READ) begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_adr_o <= A_RES;
              wb_dat_o <= '0;
              tmo      <= '0;
              state    <= S_RESULT;
            end else begin
              state <= S_DONE;
            end
          end else if (polls == PMAX) begin
            rsp_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= A_STAT;
            wb_dat_o <= '0;
            tmo      <= '0;
            state    <= S_POLL;
          end
        end

        S_RESULT_GAP: state <= S_DONE;

        S_DONE: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_secmem_master.sv
// Randomized bench for wb_secmem_master with a reactive Wishbone slave
// and a command-level reference model.
module tb_wb_secmem_master;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TMO  = 16;
  localparam int PMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [127:0]  key_i = '0;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;

  always #5 clk = ~clk;

  wb_secmem_master #(
    .SRAM_ADDR_WD(AW),
    .SRAM_DATA_WD(DW),
    .ACK_TIMEOUT(TMO),
    .POLL_MAX(PMAX)
  ) dut (
    .wb_clk_i (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .key_i    (key_i),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  typedef struct packed {
    logic          to;
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } tr_t;

  tr_t         obs_q[$];
  int          obs_len[$];
  tr_t         exp_q[$];
  logic [31:0] stat_q[$];
  logic [31:0] res_val = '0;
  bit          never_ack = 1'b0;
  int          gap_viol = 0;
  int          stab_viol = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // reactive slave: logs each transaction, answers status/result reads
  initial begin : slave
    logic p_stb, p_ack;
    tr_t  cur;
    int   len, dly;
    p_stb = 1'b0; p_ack = 1'b0; len = 0; dly = 0; cur = '0;
    wb_ack_i = 1'b0; wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (p_stb && p_ack) begin
        obs_q.push_back(cur); obs_len.push_back(len);
      end else if (p_stb && !wb_stb_o) begin
        cur.to = 1'b1;
        obs_q.push_back(cur); obs_len.push_back(len);
      end
      if (wb_stb_o) begin
        if (p_stb && p_ack) gap_viol++;
        if (!p_stb || p_ack) begin
          cur.to  = 1'b0;
          cur.we  = wb_we_o;
          cur.adr = wb_adr_o;
          cur.dat = wb_we_o ? wb_dat_o : 32'd0;
          len = 1;
          dly = $urandom_range(0, 2);
        end else begin
          len++;
          if (cur.we !== wb_we_o || cur.adr !== wb_adr_o ||
              (wb_we_o && cur.dat !== wb_dat_o)) stab_viol++;
        end
        if (!wb_cyc_o) stab_viol++;
        wb_ack_i = !never_ack && (len > dly);
        wb_dat_i = $urandom;
        if (wb_ack_i && !wb_we_o) begin
          if (wb_adr_o == 8'd2) begin
            if (stat_q.size() != 0) wb_dat_i = stat_q.pop_front();
            else wb_dat_i = '0;
          end else if (wb_adr_o == 8'd1) begin
            wb_dat_i = res_val;
          end
        end
      end else begin
        wb_ack_i = ($urandom_range(0, 3) == 0);
        wb_dat_i = $urandom;
      end
      p_stb = wb_stb_o;
      p_ack = wb_ack_i;
    end
  end

  function automatic tr_t mk(input logic we, input logic [AW-1:0] adr,
                             input logic [31:0] dat);
    tr_t t;
    t.to = 1'b0; t.we = we; t.adr = adr; t.dat = we ? dat : 32'd0;
    return t;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input logic [127:0] key,
                         input int nstat, input bit na,
                         input logic [31:0] res);
    bit          e_err;
    logic [31:0] e_rd;
    bit          idle;
    bit          got;
    int          n;
    tr_t         t;
    stat_q.delete();
    for (int i = 0; i < nstat; i++)
      stat_q.push_back(($urandom & ~32'h3) | 32'($urandom_range(1, 3)));
    stat_q.push_back($urandom & ~32'h3);
    res_val = res;
    never_ack = na;
    obs_q.delete(); obs_len.delete();
    gap_viol = 0; stab_viol = 0;

    // reference: list of bus transactions and the response
    exp_q.delete();
    e_err = 1'b0; e_rd = '0;
    if ((op == 2'd1 || op == 2'd2) && addr < 4) begin
      e_err = 1'b1;
    end else begin
      case (op)
        2'd0: for (int w = 0; w < 4; w++)
                exp_q.push_back(mk(1'b1, 8'd0, key[127 - 32*w -: 32]));
        2'd1: exp_q.push_back(mk(1'b1, addr, wd));
        2'd2: exp_q.push_back(mk(1'b0, addr, 32'd0));
        default: exp_q.push_back(mk(1'b1, 8'd3, 32'd0));
      endcase
      if (op == 2'd1 || op == 2'd2) begin
        idle = 1'b0;
        for (int i = 0; i < PMAX && !idle; i++) begin
          exp_q.push_back(mk(1'b0, 8'd2, 32'd0));
          idle = (i >= nstat);
        end
        if (!idle) e_err = 1'b1;
        else if (op == 2'd2) begin
          exp_q.push_back(mk(1'b0, 8'd1, 32'd0));
          e_rd = res;
        end
      end
      if (na) begin
        t = exp_q[0]; t.to = 1'b1;
        exp_q.delete(); exp_q.push_back(t);
        e_err = 1'b1; e_rd = '0;
      end
    end

    @(negedge clk);
    chk("ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    cmd_wdata = wd; key_i = key;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = $urandom; key_i = {4{$urandom}};
    chk("ready_busy", 64'(cmd_ready), 64'd0);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk("rsp_seen", 64'(got), 64'd1);
    if (!got) return;
    chk("rsp_err", 64'(rsp_err), 64'(e_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    @(negedge clk);
    chk("rsp_pulse", 64'(rsp_valid), 64'd0);
    chk("ready_after", 64'(cmd_ready), 64'd1);
    chk("n_trans", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("trans", 64'(obs_q[i]), 64'(exp_q[i]));
      if (exp_q[i].to) chk("tmo_len", 64'(obs_len[i]), 64'(TMO));
    end
    chk("gap", 64'(gap_viol), 64'd0);
    chk("stable", 64'(stab_viol), 64'd0);
  endtask

  initial begin : main
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_stb", 64'(wb_stb_o), 64'd0);
    chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("sel", 64'(wb_sel_o), 64'hF);
    rst = 1'b0;

    run_cmd(2'd0, 8'd0, 32'd0, 128'h00112233_44556677_8899AABB_CCDDEEFF,
            0, 1'b0, 32'd0);
    run_cmd(2'd0, 8'd0, 32'd0, 128'h00000000_12345678_00000000_0000ABCD,
            0, 1'b0, 32'd0);
    run_cmd(2'd1, 8'd8, 32'hDEADBEEF, 128'd0, 2, 1'b0, 32'd0);
    run_cmd(2'd2, 8'd12, 32'd0, 128'd0, 1, 1'b0, 32'hCAFEF00D);
    run_cmd(2'd3, 8'd0, 32'd0, 128'd0, 0, 1'b0, 32'd0);
    run_cmd(2'd1, 8'd20, 32'h1234_5678, 128'd0, 0, 1'b1, 32'd0);
    run_cmd(2'd2, 8'd2, 32'd0, 128'd0, 0, 1'b0, 32'h5555_AAAA);
    run_cmd(2'd1, 8'd3, 32'h1, 128'd0, 0, 1'b0, 32'd0);
    run_cmd(2'd1, 8'd4, 32'hA5A5_0F0F, 128'd0, 4, 1'b0, 32'd0);
    run_cmd(2'd2, 8'd255, 32'd0, 128'd0, 3, 1'b0, 32'h0BAD_F00D);

    // reset while a transaction is pending
    never_ack = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 8'd40; cmd_wdata = 32'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (wb_stb_o) seen = 1'b1;
      else @(negedge clk);
    end
    chk("mid_stb", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_stb", 64'(wb_stb_o), 64'd0);
    chk("mr_cyc", 64'(wb_cyc_o), 64'd0);
    chk("mr_bus", 64'({wb_we_o, wb_adr_o, wb_dat_o}), 64'd0);
    chk("mr_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_ready", 64'(cmd_ready), 64'd1);
    chk("mr_norsp", 64'(rsp_valid), 64'd0);
    run_cmd(2'd2, 8'd100, 32'd0, 128'd0, 1, 1'b0, 32'h1357_9BDF);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]    op;
      logic [AW-1:0] a;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(0, 3));
      else a = 8'($urandom_range(4, 255));
      run_cmd(op, a, $urandom, {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 5), ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
